// File: rtl/qpix_cfg_deserializer_if.sv
// Serial config link bundle: sclk/sdata/load in, frame data and status out.
// master drives the serial side; slave is the deserializer.
interface qpix_cfg_deserializer_if #(
  parameter int DATA_W = 32
);
  logic              sclk_in;
  logic              sdata_in;
  logic              load_in;
  logic [DATA_W-1:0] data_out;
  logic              data_valid;
  logic              err_len;
  logic              err_timeout;
  logic [5:0]        bit_cnt;
  logic [7:0]        frame_cnt;
  logic              busy;

  modport master (
    output sclk_in, sdata_in, load_in,
    input  data_out, data_valid, err_len,
    input  err_timeout, bit_cnt, frame_cnt, busy
  );

  modport slave (
    input  sclk_in, sdata_in, load_in,
    output data_out, data_valid, err_len,
    output err_timeout, bit_cnt, frame_cnt, busy
  );
endinterface

// File: rtl/qpix_cfg_deserializer.sv
// Config deserializer: syncs sclk/sdata/load into clk, shifts MSB-first and
// commits a frame on load rise. Ports: clk, rst_n, bus (slave modport).
// Optional idle abort: define QPIX_CFG_RX_TIMEOUT_EN.
module qpix_cfg_deserializer #(
  parameter int DATA_W      = 32,
  parameter int TIMEOUT_CYC = 1024
) (
  input logic                    clk,
  input logic                    rst_n,
  qpix_cfg_deserializer_if.slave bus
);

  typedef enum logic [1:0] {
    IDLE,
    SHIFT,
    HOLD
  } state_t;

  localparam logic [6:0] FULL = 7'(DATA_W);

  state_t state, state_nx;

  logic sclk_s1, sclk_s2, sclk_d;
  logic sdata_s1, sdata_s2;
  logic load_s1, load_s2, load_d;

  logic sclk_rise, load_rise, load_fall;
  logic commit, good, bad, shift_en, clr;
  logic to_hit;

  logic [DATA_W-1:0] sreg;
  logic [DATA_W-1:0] data_q;
  logic [5:0]        bit_cnt_q;
  logic [7:0]        frame_q;
  logic              dv_q, el_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sclk_s1  <= 1'b0;
      sclk_s2  <= 1'b0;
      sclk_d   <= 1'b0;
      sdata_s1 <= 1'b0;
      sdata_s2 <= 1'b0;
      load_s1  <= 1'b0;
      load_s2  <= 1'b0;
      load_d   <= 1'b0;
    end else begin
      sclk_s1  <= bus.sclk_in;
      sclk_s2  <= sclk_s1;
      sclk_d   <= sclk_s2;
      sdata_s1 <= bus.sdata_in;
      sdata_s2 <= sdata_s1;
      load_s1  <= bus.load_in;
      load_s2  <= load_s1;
      load_d   <= load_s2;
    end
  end

  assign sclk_rise = sclk_s2 & ~sclk_d;
  assign load_rise = load_s2 & ~load_d;
  assign load_fall = ~load_s2 & load_d;

`ifdef QPIX_CFG_RX_TIMEOUT_EN
  localparam int TW = $clog2(TIMEOUT_CYC + 1);
  logic [TW-1:0] to_cnt;
  logic          to_q;

  // counts clk cycles since SHIFT entry or the last sclk edge
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)
      to_cnt <= '0;
    else if (state != SHIFT || sclk_rise)
      to_cnt <= '0;
    else
      to_cnt <= to_cnt + 1'b1;
  end

  assign to_hit = (state == SHIFT) && !sclk_rise
               && !load_rise
               && (to_cnt == TW'(TIMEOUT_CYC - 1));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) to_q <= 1'b0;
    else        to_q <= to_hit;
  end

  assign bus.err_timeout = to_q;
`else
  localparam int unused_timeout_cyc = TIMEOUT_CYC;
  assign to_hit          = 1'b0;
  assign bus.err_timeout = 1'b0;
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    unique case (state)
      IDLE: begin
        if (load_rise)      state_nx = HOLD;
        else if (sclk_rise) state_nx = SHIFT;
      end
      SHIFT: begin
        if (load_rise)   state_nx = HOLD;
        else if (to_hit) state_nx = IDLE;
      end
      HOLD: begin
        if (load_fall) state_nx = IDLE;
      end
      default: state_nx = IDLE;
    endcase
  end

  // load wins over a coincident sclk edge; HOLD ignores sclk
  always_comb begin
    commit   = load_rise && (state != HOLD);
    good     = commit && ({1'b0, bit_cnt_q} == FULL);
    bad      = commit && !good;
    shift_en = sclk_rise && !load_rise
            && (state != HOLD) && !to_hit;
    clr      = commit || to_hit;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sreg      <= '0;
      bit_cnt_q <= '0;
    end else if (clr) begin
      sreg      <= '0;
      bit_cnt_q <= '0;
    end else if (shift_en) begin
      sreg <= {sreg[DATA_W-2:0], sdata_s2};
      if (bit_cnt_q != 6'd63)
        bit_cnt_q <= bit_cnt_q + 6'd1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      data_q  <= '0;
      frame_q <= '0;
      dv_q    <= 1'b0;
      el_q    <= 1'b0;
    end else begin
      dv_q <= good;
      el_q <= bad;
      if (good) begin
        data_q  <= sreg;
        frame_q <= frame_q + 8'd1;
      end
    end
  end

  assign bus.data_out   = data_q;
  assign bus.data_valid = dv_q;
  assign bus.err_len    = el_q;
  assign bus.bit_cnt    = bit_cnt_q;
  assign bus.frame_cnt  = frame_q;
  assign bus.busy       = (state != IDLE);

endmodule

// File: tb/tb_qpix_cfg_deserializer.sv
// Directed bench for qpix_cfg_deserializer.
// Build with QPIX_CFG_RX_TIMEOUT_EN to exercise the idle abort.
module tb_qpix_cfg_deserializer;
  localparam int DW = 32;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;

  qpix_cfg_deserializer_if #(.DATA_W(DW)) bus ();

  qpix_cfg_deserializer #(
    .DATA_W(DW),
    .TIMEOUT_CYC(64)
  ) dut (
    .clk(clk),
    .rst_n(rst_n),
    .bus(bus)
  );

  always #10 clk = ~clk;

  int checks   = 0;
  int failures = 0;
  int dv_cnt   = 0;
  int el_cnt   = 0;
  int to_cnt   = 0;
  int both_cnt = 0;

  always @(negedge clk) begin
    if (bus.data_valid) dv_cnt++;
    if (bus.err_len) el_cnt++;
    if (bus.err_timeout) to_cnt++;
    if (bus.data_valid && bus.err_len) both_cnt++;
  end

  task automatic wait_n(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic clr_mon();
    @(posedge clk);
    dv_cnt = 0;
    el_cnt = 0;
    to_cnt = 0;
  endtask

  task automatic send_bit(input logic b);
    @(negedge clk);
    bus.sdata_in = b;
    wait_n(4);
    bus.sclk_in = 1'b1;
    wait_n(4);
    bus.sclk_in = 1'b0;
  endtask

  task automatic send_bits(input logic [31:0] w, input int n);
    for (int i = n - 1; i >= 0; i--) send_bit(w[i]);
    wait_n(4);
  endtask

  task automatic pulse_load();
    @(negedge clk);
    bus.load_in = 1'b1;
    wait_n(6);
    bus.load_in = 1'b0;
    wait_n(6);
  endtask

  task automatic test_reset();
    wait_n(3);
    checks++;
    if (bus.data_out !== 32'h0) begin
      failures++;
      $display("FAIL rst_data got=%h exp=0", bus.data_out);
    end
    checks++;
    if (bus.bit_cnt !== 6'd0 || bus.frame_cnt !== 8'd0) begin
      failures++;
      $display("FAIL rst_cnt got=%0d/%0d exp=0/0",
               bus.bit_cnt, bus.frame_cnt);
    end
    checks++;
    if ({bus.data_valid, bus.err_len,
         bus.err_timeout, bus.busy} !== 4'b0) begin
      failures++;
      $display("FAIL rst_flags got=%b exp=0000",
               {bus.data_valid, bus.err_len,
                bus.err_timeout, bus.busy});
    end
    @(negedge clk);
    rst_n = 1'b1;
    wait_n(3);
  endtask

  task automatic test_good_frame();
    clr_mon();
    send_bits(32'h1db6ff8b, 32);
    checks++;
    if (bus.bit_cnt !== 6'd32 || bus.busy !== 1'b1) begin
      failures++;
      $display("FAIL good_pre got=%0d/%b exp=32/1",
               bus.bit_cnt, bus.busy);
    end
    pulse_load();
    checks++;
    if (bus.data_out !== 32'h1db6ff8b) begin
      failures++;
      $display("FAIL good_data got=%h exp=1db6ff8b", bus.data_out);
    end
    checks++;
    if (dv_cnt !== 1 || el_cnt !== 0) begin
      failures++;
      $display("FAIL good_pulse got=%0d/%0d exp=1/0", dv_cnt, el_cnt);
    end
    checks++;
    if (bus.frame_cnt !== 8'd1 || bus.bit_cnt !== 6'd0) begin
      failures++;
      $display("FAIL good_cnt got=%0d/%0d exp=1/0",
               bus.frame_cnt, bus.bit_cnt);
    end
    checks++;
    if (bus.busy !== 1'b0) begin
      failures++;
      $display("FAIL good_busy got=%b exp=0", bus.busy);
    end
  endtask

  task automatic test_short();
    clr_mon();
    send_bits(32'h0000_1234, 31);
    checks++;
    if (bus.bit_cnt !== 6'd31) begin
      failures++;
      $display("FAIL short_bits got=%0d exp=31", bus.bit_cnt);
    end
    pulse_load();
    checks++;
    if (el_cnt !== 1 || dv_cnt !== 0) begin
      failures++;
      $display("FAIL short_pulse got=%0d/%0d exp=1/0", el_cnt, dv_cnt);
    end
    checks++;
    if (bus.data_out !== 32'h1db6ff8b || bus.frame_cnt !== 8'd1) begin
      failures++;
      $display("FAIL short_keep got=%h/%0d exp=1db6ff8b/1",
               bus.data_out, bus.frame_cnt);
    end
  endtask

  task automatic test_zero_bits();
    clr_mon();
    pulse_load();
    checks++;
    if (el_cnt !== 1 || dv_cnt !== 0 || bus.frame_cnt !== 8'd1) begin
      failures++;
      $display("FAIL zero_len got=%0d/%0d/%0d exp=1/0/1",
               el_cnt, dv_cnt, bus.frame_cnt);
    end
  endtask

  task automatic test_saturate();
    clr_mon();
    send_bits(32'hffff_ffff, 32);
    send_bits(32'h0000_0000, 32);
    send_bits(32'h0000_002a, 6);
    checks++;
    if (bus.bit_cnt !== 6'd63) begin
      failures++;
      $display("FAIL sat_bits got=%0d exp=63", bus.bit_cnt);
    end
    pulse_load();
    checks++;
    if (el_cnt !== 1 || dv_cnt !== 0) begin
      failures++;
      $display("FAIL sat_pulse got=%0d/%0d exp=1/0", el_cnt, dv_cnt);
    end
    checks++;
    if (bus.data_out !== 32'h1db6ff8b || bus.frame_cnt !== 8'd1) begin
      failures++;
      $display("FAIL sat_keep got=%h/%0d exp=1db6ff8b/1",
               bus.data_out, bus.frame_cnt);
    end
  endtask

  task automatic test_coincident();
    clr_mon();
    send_bits(32'h1234_5678, 32);
    @(negedge clk);
    bus.sdata_in = 1'b1;
    bus.sclk_in  = 1'b1;
    bus.load_in  = 1'b1;
    wait_n(5);
    bus.sclk_in = 1'b0;
    wait_n(4);
    send_bit(1'b1);
    send_bit(1'b0);
    send_bit(1'b1);
    wait_n(4);
    checks++;
    if (bus.bit_cnt !== 6'd0 || bus.busy !== 1'b1) begin
      failures++;
      $display("FAIL hold_ignore got=%0d/%b exp=0/1",
               bus.bit_cnt, bus.busy);
    end
    bus.load_in = 1'b0;
    wait_n(6);
    checks++;
    if (bus.data_out !== 32'h1234_5678) begin
      failures++;
      $display("FAIL coin_data got=%h exp=12345678", bus.data_out);
    end
    checks++;
    if (dv_cnt !== 1 || el_cnt !== 0 || bus.frame_cnt !== 8'd2) begin
      failures++;
      $display("FAIL coin_pulse got=%0d/%0d/%0d exp=1/0/2",
               dv_cnt, el_cnt, bus.frame_cnt);
    end
    checks++;
    if (bus.bit_cnt !== 6'd0 || bus.busy !== 1'b0) begin
      failures++;
      $display("FAIL coin_idle got=%0d/%b exp=0/0",
               bus.bit_cnt, bus.busy);
    end
  endtask

  task automatic test_idle_sclk();
    clr_mon();
    send_bits(32'h0000_02ab, 10);
`ifdef QPIX_CFG_RX_TIMEOUT_EN
    wait_n(45);
    checks++;
    if (to_cnt !== 0 || bus.bit_cnt !== 6'd10) begin
      failures++;
      $display("FAIL to_early got=%0d/%0d exp=0/10",
               to_cnt, bus.bit_cnt);
    end
    wait_n(40);
    checks++;
    if (to_cnt !== 1 || el_cnt !== 0) begin
      failures++;
      $display("FAIL to_pulse got=%0d/%0d exp=1/0", to_cnt, el_cnt);
    end
    checks++;
    if (bus.bit_cnt !== 6'd0 || bus.busy !== 1'b0) begin
      failures++;
      $display("FAIL to_idle got=%0d/%b exp=0/0",
               bus.bit_cnt, bus.busy);
    end
`else
    wait_n(200);
    checks++;
    if (to_cnt !== 0 || bus.bit_cnt !== 6'd10 || bus.busy !== 1'b1) begin
      failures++;
      $display("FAIL no_to got=%0d/%0d/%b exp=0/10/1",
               to_cnt, bus.bit_cnt, bus.busy);
    end
    pulse_load();
    checks++;
    if (el_cnt !== 1 || dv_cnt !== 0) begin
      failures++;
      $display("FAIL no_to_len got=%0d/%0d exp=1/0", el_cnt, dv_cnt);
    end
`endif
  endtask

  task automatic test_reset_mid();
    clr_mon();
    send_bits(32'h0000_beef, 16);
    @(negedge clk);
    rst_n = 1'b0;
    wait_n(3);
    checks++;
    if (bus.data_out !== 32'h0 || bus.frame_cnt !== 8'd0
        || bus.bit_cnt !== 6'd0 || bus.busy !== 1'b0) begin
      failures++;
      $display("FAIL mid_rst got=%h/%0d/%0d/%b exp=0/0/0/0",
               bus.data_out, bus.frame_cnt, bus.bit_cnt, bus.busy);
    end
    checks++;
    if (el_cnt !== 0 || dv_cnt !== 0 || to_cnt !== 0) begin
      failures++;
      $display("FAIL mid_rst_err got=%0d/%0d/%0d exp=0/0/0",
               el_cnt, dv_cnt, to_cnt);
    end
    rst_n = 1'b1;
    wait_n(3);
    send_bits(32'ha5a5_a5a5, 32);
    pulse_load();
    checks++;
    if (bus.data_out !== 32'ha5a5_a5a5 || bus.frame_cnt !== 8'd1) begin
      failures++;
      $display("FAIL mid_next got=%h/%0d exp=a5a5a5a5/1",
               bus.data_out, bus.frame_cnt);
    end
    checks++;
    if (dv_cnt !== 1 || el_cnt !== 0) begin
      failures++;
      $display("FAIL mid_pulse got=%0d/%0d exp=1/0", dv_cnt, el_cnt);
    end
  endtask

  task automatic test_exclusive();
    checks++;
    if (both_cnt !== 0) begin
      failures++;
      $display("FAIL excl got=%0d exp=0", both_cnt);
    end
  endtask

  initial begin
    bus.sclk_in  = 1'b0;
    bus.sdata_in = 1'b0;
    bus.load_in  = 1'b0;
    test_reset();
    test_good_frame();
    test_short();
    test_zero_bits();
    test_saturate();
    test_coincident();
    test_idle_sclk();
    test_reset_mid();
    test_exclusive();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
